// File: rtl/uart_transmitter_top_pkg.sv
// Shared definitions for the UART transmitter: FSM encoding, word-length codes
// and the word-length decode helpers.
package uart_transmitter_top_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP1  = 3'd4,
        ST_STOP2  = 3'd5
    } tx_state_t;

    localparam logic [1:0] WLS_5 = 2'b00;
    localparam logic [1:0] WLS_6 = 2'b01;
    localparam logic [1:0] WLS_7 = 2'b10;
    localparam logic [1:0] WLS_8 = 2'b11;

    function automatic logic [3:0] word_len(input logic [1:0] w);
        return {2'b00, w} + 4'd5;
    endfunction

    // Keeps only the bits that belong to the configured word length.
    function automatic logic [7:0] word_mask(input logic [1:0] w);
        case (w)
            WLS_5:   return 8'h1F;
            WLS_6:   return 8'h3F;
            WLS_7:   return 8'h7F;
            default: return 8'hFF;
        endcase
    endfunction

endpackage

// File: rtl/uart_transmitter_top_parity_generator.sv
// Combinational parity bit for one transmit character; counterpart of the
// receiver's parity checker.
module parity_generator
    import uart_transmitter_top_pkg::*;
(
    input  logic [7:0] i_data,
    input  logic [1:0] i_wls,
    input  logic       i_pen,
    input  logic       i_eps,
    input  logic       i_sp,
    output logic       o_par
);

    logic [7:0] w_bits;

    assign w_bits = i_data & word_mask(i_wls);

    always_comb begin
        o_par = 1'b0;
        if (!i_pen)     o_par = 1'b0;
        else if (i_sp)  o_par = ~i_eps;
        else if (i_eps) o_par = ^w_bits;
        else            o_par = ~^w_bits;
    end

endmodule

// File: rtl/uart_transmitter_top.sv
// UART transmitter: pops one character from the THR per frame and serialises
// start / data (LSB first) / optional parity / 1-2 stop bits onto the line.
module uart_transmitter_top
    import uart_transmitter_top_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter bit IDLE_LEVEL = 1'b1
) (
    input  logic              pclk,
    input  logic              presetn,
    input  logic              utrrst,
    input  logic              transmit_edge,
    input  logic [DATA_W-1:0] thr_data,
    input  logic              thr_empty,
    input  logic [1:0]        wls,
    input  logic              pen,
    input  logic              eps,
    input  logic              sp,
    input  logic              stb,
    input  logic              bc,
    input  logic              loop,
    output logic              thr_read,
    output logic              uart_txd,
    output logic              loop_txd,
    output logic              tsr_empty
);

    tx_state_t         r_state;
    logic [2:0]        r_cnt;
    logic [DATA_W-1:0] r_tsr;
    logic [1:0]        r_wls;
    logic              r_pen;
    logic              r_stb;
    logic              r_par;
    logic              r_lvl;
    logic              r_bc;

    logic w_par;
    logic w_frame_end;
    logic w_load;
    logic w_s;

    parity_generator u_parity (
        .i_data (thr_data),
        .i_wls  (wls),
        .i_pen  (pen),
        .i_eps  (eps),
        .i_sp   (sp),
        .o_par  (w_par)
    );

    // Reloading straight out of the last stop bit keeps frames contiguous.
    assign w_frame_end = transmit_edge &
                         (((r_state == ST_STOP1) & !r_stb) | (r_state == ST_STOP2));
    assign w_load      = !utrrst & !thr_empty &
                         ((transmit_edge & (r_state == ST_IDLE)) | w_frame_end);

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_tsr   <= '0;
            r_wls   <= WLS_5;
            r_pen   <= 1'b0;
            r_stb   <= 1'b0;
            r_par   <= 1'b0;
            r_lvl   <= IDLE_LEVEL;
            r_bc    <= 1'b0;
        end else if (utrrst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_tsr   <= '0;
            r_wls   <= WLS_5;
            r_pen   <= 1'b0;
            r_stb   <= 1'b0;
            r_par   <= 1'b0;
            r_lvl   <= IDLE_LEVEL;
            r_bc    <= 1'b0;
        end else begin
            r_bc <= bc;
            if (w_load) begin
                // Frame configuration is frozen here so later register writes
                // only affect the next character.
                r_tsr   <= thr_data & word_mask(wls);
                r_wls   <= wls;
                r_pen   <= pen;
                r_stb   <= stb;
                r_par   <= w_par;
                r_state <= ST_START;
                r_lvl   <= ~IDLE_LEVEL;
            end else if (transmit_edge) begin
                case (r_state)
                    ST_START: begin
                        r_state <= ST_DATA;
                        r_cnt   <= '0;
                        r_lvl   <= r_tsr[0];
                    end
                    ST_DATA: begin
                        if ({1'b0, r_cnt} == word_len(r_wls) - 4'd1) begin
                            r_state <= r_pen ? ST_PARITY : ST_STOP1;
                            r_lvl   <= r_pen ? r_par : IDLE_LEVEL;
                        end else begin
                            r_cnt <= r_cnt + 3'd1;
                            r_tsr <= r_tsr >> 1;
                            r_lvl <= r_tsr[1];
                        end
                    end
                    ST_PARITY: begin
                        r_state <= ST_STOP1;
                        r_lvl   <= IDLE_LEVEL;
                    end
                    ST_STOP1: begin
                        r_state <= r_stb ? ST_STOP2 : ST_IDLE;
                        r_lvl   <= IDLE_LEVEL;
                    end
                    ST_STOP2: begin
                        r_state <= ST_IDLE;
                        r_lvl   <= IDLE_LEVEL;
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_lvl   <= IDLE_LEVEL;
                    end
                endcase
            end
        end
    end

    // Break overrides the line without disturbing the FSM level underneath.
    assign w_s       = r_lvl & ~r_bc;
    assign loop_txd  = w_s;
    assign uart_txd  = loop ? IDLE_LEVEL : w_s;
    assign tsr_empty = (r_state == ST_IDLE);
    assign thr_read  = w_load;

endmodule

// File: tb/tb_uart_transmitter_top.sv
// Directed bench for uart_transmitter_top: vector table of single frames plus
// hand sequences for back-to-back frames, break, soft reset and async reset.
module tb_uart_transmitter_top;

    logic       pclk = 1'b0;
    logic       presetn;
    logic       utrrst;
    logic       transmit_edge;
    logic [7:0] thr_data;
    logic       thr_empty;
    logic [1:0] wls;
    logic       pen, eps, sp, stb, bc, loop;
    logic       thr_read, uart_txd, loop_txd, tsr_empty;

    uart_transmitter_top dut (
        .pclk          (pclk),
        .presetn       (presetn),
        .utrrst        (utrrst),
        .transmit_edge (transmit_edge),
        .thr_data      (thr_data),
        .thr_empty     (thr_empty),
        .wls           (wls),
        .pen           (pen),
        .eps           (eps),
        .sp            (sp),
        .stb           (stb),
        .bc            (bc),
        .loop          (loop),
        .thr_read      (thr_read),
        .uart_txd      (uart_txd),
        .loop_txd      (loop_txd),
        .tsr_empty     (tsr_empty)
    );

    always #5 pclk = ~pclk;

    typedef struct {
        logic [7:0]  data;
        logic [1:0]  wls;
        logic        pen;
        logic        eps;
        logic        sp;
        logic        stb;
        logic        loop;
        int          n;
        logic [0:15] exp;   // line level after edge i, left to right
    } vec_t;

    vec_t        vt [8];
    logic [7:0]  q [$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic        line, lline, emp, rd, bcact;
    int          nrd;
    int          rd_e [2];
    logic [0:31] b2b_exp;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic fifo_drive();
        thr_empty = (q.size() == 0);
        thr_data  = (q.size() != 0) ? q[0] : 8'h00;
    endtask

    // One bit period: edge pulse for one cycle, pop on observed read, then
    // sample the line the cycle after the edge.
    task automatic do_edge(output logic o_line, output logic o_lline,
                           output logic o_emp, output logic o_rd);
        @(posedge pclk); #1 transmit_edge = 1'b1;
        @(negedge pclk); o_rd = thr_read;
        @(posedge pclk); #1 transmit_edge = 1'b0;
        if (o_rd && q.size() != 0) begin
            void'(q.pop_front());
            fifo_drive();
        end
        @(negedge pclk);
        o_line  = uart_txd;
        o_lline = loop_txd;
        o_emp   = tsr_empty;
    endtask

    initial begin
        vt[0] = '{8'hA5, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 11, 16'b0101001011100000};
        vt[1] = '{8'h07, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0,  9, 16'b0111001110000000};
        vt[2] = '{8'h07, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,  9, 16'b0111000110000000};
        vt[3] = '{8'h07, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0,  9, 16'b0111000110000000};
        vt[4] = '{8'h3C, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 11, 16'b0001111001100000};
        vt[5] = '{8'hFF, 2'b01, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 11, 16'b0111111111100000};
        vt[6] = '{8'hE0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0,  9, 16'b0000000110000000};
        vt[7] = '{8'h55, 2'b10, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 11, 16'b0101010111100000};
        b2b_exp = 32'b01000000111001000010111_000000000;

        presetn = 1'b0; utrrst = 1'b0; transmit_edge = 1'b0;
        wls = 2'b11; pen = 1'b0; eps = 1'b0; sp = 1'b0; stb = 1'b0;
        bc = 1'b0; loop = 1'b0; bcact = 1'b0;
        fifo_drive();
        repeat (3) @(posedge pclk);
        @(negedge pclk);
        chk("rst uart_txd", uart_txd, 1'b1);
        chk("rst loop_txd", loop_txd, 1'b1);
        chk("rst tsr_empty", tsr_empty, 1'b1);
        chk("rst thr_read", thr_read, 1'b0);
        #2 presetn = 1'b1;

        do_edge(line, lline, emp, rd);
        chk("stray line", line, 1'b1);
        chk("stray empty", emp, 1'b1);
        chk("stray read", rd, 1'b0);

        for (int v = 0; v < 8; v++) begin
            wls = vt[v].wls; pen = vt[v].pen; eps = vt[v].eps; sp = vt[v].sp;
            stb = vt[v].stb; loop = vt[v].loop;
            q.push_back(vt[v].data);
            fifo_drive();
            nrd = 0;
            for (int i = 0; i < vt[v].n; i++) begin
                do_edge(line, lline, emp, rd);
                if (rd) nrd++;
                chk($sformatf("v%0d e%0d loop_txd", v, i), lline, vt[v].exp[i]);
                chk($sformatf("v%0d e%0d uart_txd", v, i), line,
                    vt[v].loop ? 1'b1 : vt[v].exp[i]);
                chk($sformatf("v%0d e%0d tsr_empty", v, i), emp, (i == vt[v].n - 1));
            end
            chk($sformatf("v%0d thr_read count", v), nrd, 1);
        end
        loop = 1'b0;

        // Two queued characters, two stop bits; pen toggled mid-frame must not leak in.
        wls = 2'b11; pen = 1'b0; stb = 1'b1;
        q.push_back(8'h81); q.push_back(8'h42);
        fifo_drive();
        nrd = 0; rd_e[0] = -1; rd_e[1] = -1;
        for (int i = 0; i < 23; i++) begin
            do_edge(line, lline, emp, rd);
            if (rd) begin
                if (nrd < 2) rd_e[nrd] = i;
                nrd++;
            end
            chk($sformatf("b2b e%0d line", i), line, b2b_exp[i]);
            chk($sformatf("b2b e%0d tsr_empty", i), emp, (i == 22));
            if (i == 2) pen = 1'b1;
            if (i == 5) pen = 1'b0;
        end
        chk("b2b read count", nrd, 2);
        chk("b2b first read edge", rd_e[0], 0);
        chk("b2b second read edge", rd_e[1], 11);
        stb = 1'b0;

        // Break during DATA, released mid-frame.
        q.push_back(8'hA5);
        fifo_drive();
        nrd = 0; bcact = 1'b0;
        for (int i = 0; i < 11; i++) begin
            do_edge(line, lline, emp, rd);
            if (rd) nrd++;
            chk($sformatf("brk e%0d line", i), line, bcact ? 1'b0 : vt[0].exp[i]);
            if (i == 3) begin
                bc = 1'b1;
                @(posedge pclk); @(negedge pclk);
                chk("brk assert line", uart_txd, 1'b0);
                bcact = 1'b1;
            end
            if (i == 6) begin
                bc = 1'b0;
                @(posedge pclk); @(negedge pclk);
                chk("brk release line", uart_txd, vt[0].exp[6]);
                bcact = 1'b0;
            end
        end
        chk("brk read count", nrd, 1);
        chk("brk final empty", emp, 1'b1);

        // Soft reset during data bit 3 with another character waiting.
        q.push_back(8'hA5); q.push_back(8'h11);
        fifo_drive();
        for (int i = 0; i < 5; i++) do_edge(line, lline, emp, rd);
        chk("utrrst pre line", line, 1'b0);
        chk("utrrst pre empty", emp, 1'b0);
        utrrst = 1'b1;
        #1 chk("utrrst read mid", thr_read, 1'b0);
        @(posedge pclk); #1 utrrst = 1'b0;
        @(negedge pclk);
        chk("utrrst uart_txd", uart_txd, 1'b1);
        chk("utrrst loop_txd", loop_txd, 1'b1);
        chk("utrrst tsr_empty", tsr_empty, 1'b1);
        utrrst = 1'b1; transmit_edge = 1'b1;
        #1 chk("utrrst read idle", thr_read, 1'b0);
        @(posedge pclk); #1 utrrst = 1'b0; transmit_edge = 1'b0;
        @(negedge pclk);
        chk("utrrst still idle", tsr_empty, 1'b1);
        q.delete();
        fifo_drive();

        // Asynchronous reset in the middle of a frame.
        q.push_back(8'h00);
        fifo_drive();
        for (int i = 0; i < 3; i++) do_edge(line, lline, emp, rd);
        chk("presetn pre line", line, 1'b0);
        #2 presetn = 1'b0;
        #1;
        chk("presetn uart_txd", uart_txd, 1'b1);
        chk("presetn loop_txd", loop_txd, 1'b1);
        chk("presetn tsr_empty", tsr_empty, 1'b1);
        chk("presetn thr_read", thr_read, 1'b0);
        @(posedge pclk); #1 presetn = 1'b1;
        do_edge(line, lline, emp, rd);
        chk("post rst line", line, 1'b1);
        chk("post rst read", rd, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
